// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared map RAM geometry, cell types and log-odds constants
package ram_pkg;

    localparam int MAP_W   = 256;
    localparam int MAP_H   = 256;
    localparam int INDEX_W = 8;
    localparam int CELL_W  = 8;
    localparam int ADDR_W  = $clog2(MAP_W * MAP_H);

    localparam int L_OCC  = 7;
    localparam int L_FREE = -3;
    localparam int L_MIN  = -64;
    localparam int L_MAX  = 63;

    typedef logic [INDEX_W-1:0]       index_t;
    typedef logic signed [CELL_W-1:0] cell_t;
    typedef logic [ADDR_W-1:0]        map_addr_t;

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_DRAIN,
        ST_CLEAR
    } upd_state_t;

endpackage

// File: rtl/occupancy_grid_updater_saturate.sv
// rtl/occupancy_grid_updater_saturate.sv - log-odds add with clamp to [L_MIN, L_MAX]
module log_odds_saturate #(
    parameter int CELL_W = 8,
    parameter int L_MIN  = -64,
    parameter int L_MAX  = 63
) (
    input  logic signed [CELL_W-1:0] old_val,
    input  logic signed [CELL_W-1:0] inc,
    output logic signed [CELL_W-1:0] new_val
);

    localparam logic signed [CELL_W:0] MIN_W = (CELL_W+1)'(L_MIN);
    localparam logic signed [CELL_W:0] MAX_W = (CELL_W+1)'(L_MAX);

    logic signed [CELL_W:0] sum;

    // One extra bit of headroom so the sum never wraps before the clamp
    always_comb begin
        sum = {old_val[CELL_W-1], old_val} + {inc[CELL_W-1], inc};
        if (sum > MAX_W) begin
            new_val = MAX_W[CELL_W-1:0];
        end else if (sum < MIN_W) begin
            new_val = MIN_W[CELL_W-1:0];
        end else begin
            new_val = sum[CELL_W-1:0];
        end
    end

endmodule

// File: rtl/occupancy_grid_updater.sv
// rtl/occupancy_grid_updater.sv - pipelined log-odds read-modify-write of map RAM with whole-map clear
module occupancy_grid_updater
    import ram_pkg::*;
#(
    parameter int MAP_W  = ram_pkg::MAP_W,
    parameter int MAP_H  = ram_pkg::MAP_H,
    parameter int CELL_W = ram_pkg::CELL_W,
    parameter int L_OCC  = ram_pkg::L_OCC,
    parameter int L_FREE = ram_pkg::L_FREE,
    parameter int L_MIN  = ram_pkg::L_MIN,
    parameter int L_MAX  = ram_pkg::L_MAX,
    localparam int ADDR_W = $clog2(MAP_W * MAP_H)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  index_t            x_index,
    input  index_t            y_index,
    input  logic              hit,
    input  logic              last,
    input  logic              clear_req,
    output logic              clear_done,
    output logic              ray_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [CELL_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [CELL_W-1:0] wr_data,
    output logic [15:0]       dropped_count
);

    localparam logic [ADDR_W-1:0]        LAST_ADDR = ADDR_W'(MAP_W * MAP_H - 1);
    localparam logic signed [CELL_W-1:0] OCC_C     = CELL_W'(L_OCC);
    localparam logic signed [CELL_W-1:0] FREE_C    = CELL_W'(L_FREE);

    upd_state_t state;
    logic [ADDR_W-1:0] clr_addr;

    logic              accept;
    logic              in_bounds;
    logic [31:0]       addr_full;
    logic [ADDR_W-1:0] in_addr;

    logic              s1_valid, s1_inb, s1_hit, s1_last;
    logic [ADDR_W-1:0] s1_addr;
    logic              s2_valid, s2_inb, s2_hit, s2_last;
    logic [ADDR_W-1:0] s2_addr;

    logic              prev_wr_en;
    logic [ADDR_W-1:0] prev_wr_addr;
    logic [CELL_W-1:0] prev_wr_data;

    logic signed [CELL_W-1:0] old_val;
    logic signed [CELL_W-1:0] inc;
    logic signed [CELL_W-1:0] new_val;

    // Accept decode: bounds test and linear address of the incoming cell
    always_comb begin
        accept    = in_valid & in_ready;
        in_bounds = (int'(x_index) < MAP_W) && (int'(y_index) < MAP_H);
        addr_full = 32'(int'(y_index) * MAP_W + int'(x_index));
        in_addr   = addr_full[ADDR_W-1:0];
    end

    // Two-stage pipeline: S1 issues the read, S2 writes back; also keeps the last write for forwarding
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid      <= 1'b0;
            s1_inb        <= 1'b0;
            s1_hit        <= 1'b0;
            s1_last       <= 1'b0;
            s1_addr       <= '0;
            s2_valid      <= 1'b0;
            s2_inb        <= 1'b0;
            s2_hit        <= 1'b0;
            s2_last       <= 1'b0;
            s2_addr       <= '0;
            prev_wr_en    <= 1'b0;
            prev_wr_addr  <= '0;
            prev_wr_data  <= '0;
            dropped_count <= '0;
        end else begin
            s1_valid <= accept;
            s1_inb   <= accept & in_bounds;
            s1_hit   <= hit;
            s1_last  <= last;
            if (accept) begin
                s1_addr <= in_addr;
            end
            s2_valid     <= s1_valid;
            s2_inb       <= s1_inb;
            s2_hit       <= s1_hit;
            s2_last      <= s1_last;
            s2_addr      <= s1_addr;
            prev_wr_en   <= wr_en;
            prev_wr_addr <= wr_addr;
            prev_wr_data <= wr_data;
            if (accept && !in_bounds && dropped_count != 16'hFFFF) begin
                dropped_count <= dropped_count + 16'd1;
            end
        end
    end

    // Mode control: drain in-flight cells, then sweep the whole map with zeros
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_ACTIVE;
            in_ready <= 1'b1;
            clr_addr <= '0;
        end else begin
            case (state)
                ST_ACTIVE: begin
                    if (clear_req) begin
                        state    <= ST_DRAIN;
                        in_ready <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (!s1_valid && !s2_valid) begin
                        state    <= ST_CLEAR;
                        clr_addr <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state    <= ST_ACTIVE;
                        in_ready <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_ACTIVE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    // The RAM has not yet seen a write issued one cycle earlier, so take it from the write port instead
    always_comb begin
        inc = s2_hit ? OCC_C : FREE_C;
        if (prev_wr_en && prev_wr_addr == s2_addr) begin
            old_val = prev_wr_data;
        end else begin
            old_val = rd_data;
        end
    end

    log_odds_saturate #(
        .CELL_W (CELL_W),
        .L_MIN  (L_MIN),
        .L_MAX  (L_MAX)
    ) u_sat (
        .old_val (old_val),
        .inc     (inc),
        .new_val (new_val)
    );

    // RAM port drive: clear sweep owns the write port, otherwise S2 write-back
    always_comb begin
        rd_en      = s1_valid & s1_inb;
        rd_addr    = s1_addr;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        clear_done = 1'b0;
        ray_done   = s2_valid & s2_last;
        if (state == ST_CLEAR) begin
            wr_en      = 1'b1;
            wr_addr    = clr_addr;
            clear_done = (clr_addr == LAST_ADDR);
        end else if (s2_valid && s2_inb) begin
            wr_en   = 1'b1;
            wr_addr = s2_addr;
            wr_data = new_val;
        end
    end

endmodule

// File: tb/tb_occupancy_grid_updater.sv
// tb/tb_occupancy_grid_updater.sv - directed self-checking bench for occupancy_grid_updater
module tb_occupancy_grid_updater;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x_index;
    logic [7:0]  y_index;
    logic        hit;
    logic        last;
    logic        clear_req;
    logic        clear_done;
    logic        ray_done;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] dropped_count;

    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [7:0]  pl_data;
    logic        model_zero;
    logic [7:0]  mem [256];

    int checks;
    int failures;

    typedef struct {
        int x;
        int y;
        bit hit;
        int pre;
        int exp_addr;
        int exp_data;
    } vec_t;

    vec_t vecs[7];

    int  wi;
    int  done_idx;
    int  done_cnt;
    int  seen;
    int  nonzero;
    bit  seq_ok;

    occupancy_grid_updater #(
        .MAP_W (16),
        .MAP_H (16)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .x_index       (x_index),
        .y_index       (y_index),
        .hit           (hit),
        .last          (last),
        .clear_req     (clear_req),
        .clear_done    (clear_done),
        .ray_done      (ray_done),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .dropped_count (dropped_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Read-first RAM model with a bench-side preload port
    always @(posedge clock) begin
        if (model_zero) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'd0;
        end else begin
            if (rd_en) rd_data <= mem[rd_addr];
            if (wr_en) mem[wr_addr] <= wr_data;
            if (pl_en) mem[pl_addr] <= pl_data;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic preload(input int addr, input int val);
        @(negedge clock);
        pl_en   = 1'b1;
        pl_addr = 8'(addr);
        pl_data = 8'(val);
        @(negedge clock);
        pl_en   = 1'b0;
    endtask

    task automatic drive_cell(input int x, input int y, input bit h, input bit l);
        in_valid = 1'b1;
        x_index  = 8'(x);
        y_index  = 8'(y);
        hit      = h;
        last     = l;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        hit       = 1'b0;
        last      = 1'b0;
        clear_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_rd_en"}, int'(rd_en), 0);
        check({tag, "_wr_en"}, int'(wr_en), 0);
        check({tag, "_wr_addr"}, int'(wr_addr), 0);
        check({tag, "_wr_data"}, int'(wr_data), 0);
        check({tag, "_ray_done"}, int'(ray_done), 0);
        check({tag, "_clear_done"}, int'(clear_done), 0);
        check({tag, "_dropped"}, int'(dropped_count), 0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        pl_en      = 1'b0;
        pl_addr    = 8'd0;
        pl_data    = 8'd0;
        model_zero = 1'b1;
        x_index    = 8'd0;
        y_index    = 8'd0;
        idle_inputs();

        vecs[0] = '{x: 3,  y: 2,  hit: 1'b0, pre: 0,   exp_addr: 35,  exp_data: -3};
        vecs[1] = '{x: 15, y: 15, hit: 1'b1, pre: 0,   exp_addr: 255, exp_data: 7};
        vecs[2] = '{x: 4,  y: 1,  hit: 1'b1, pre: 60,  exp_addr: 20,  exp_data: 63};
        vecs[3] = '{x: 0,  y: 0,  hit: 1'b0, pre: -63, exp_addr: 0,   exp_data: -64};
        vecs[4] = '{x: 7,  y: 3,  hit: 1'b0, pre: -62, exp_addr: 55,  exp_data: -64};
        vecs[5] = '{x: 1,  y: 9,  hit: 1'b1, pre: 56,  exp_addr: 145, exp_data: 63};
        vecs[6] = '{x: 2,  y: 2,  hit: 1'b1, pre: -64, exp_addr: 34,  exp_data: -57};

        @(negedge clock);
        @(negedge clock);
        model_zero = 1'b0;
        #1;
        check("reset_rd_addr", int'(rd_addr), 0);
        check_reset_outputs("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // Single-cell vectors: read at T+1, write and ray_done at T+2
        for (int i = 0; i < 7; i++) begin
            preload(vecs[i].exp_addr, vecs[i].pre);
            drive_cell(vecs[i].x, vecs[i].y, vecs[i].hit, 1'b1);
            @(negedge clock);
            idle_inputs();
            check($sformatf("v%0d_rd_en", i), int'(rd_en), 1);
            check($sformatf("v%0d_rd_addr", i), int'(rd_addr), vecs[i].exp_addr);
            @(negedge clock);
            check($sformatf("v%0d_wr_en", i), int'(wr_en), 1);
            check($sformatf("v%0d_wr_addr", i), int'(wr_addr), vecs[i].exp_addr);
            check($sformatf("v%0d_wr_data", i), int'($signed(wr_data)), vecs[i].exp_data);
            check($sformatf("v%0d_ray_done", i), int'(ray_done), 1);
            @(negedge clock);
            check($sformatf("v%0d_idle_wr_en", i), int'(wr_en), 0);
        end

        // Back-to-back same cell needs the write-to-read forward
        preload(85, 10);
        drive_cell(5, 5, 1'b0, 1'b0);
        @(negedge clock);
        drive_cell(5, 5, 1'b1, 1'b1);
        @(negedge clock);
        idle_inputs();
        check("b2b_first_wr_en", int'(wr_en), 1);
        check("b2b_first_wr_data", int'($signed(wr_data)), 7);
        check("b2b_first_ray_done", int'(ray_done), 0);
        @(negedge clock);
        check("b2b_stale_rd_data", int'($signed(rd_data)), 10);
        check("b2b_second_wr_addr", int'(wr_addr), 85);
        check("b2b_second_wr_data", int'($signed(wr_data)), 14);
        check("b2b_second_ray_done", int'(ray_done), 1);
        @(negedge clock);
        check("b2b_mem", int'($signed(mem[85])), 14);

        // Out of bounds cell is dropped but still completes the ray
        drive_cell(16, 0, 1'b1, 1'b1);
        @(negedge clock);
        idle_inputs();
        check("oob_rd_en", int'(rd_en), 0);
        @(negedge clock);
        check("oob_wr_en", int'(wr_en), 0);
        check("oob_ray_done", int'(ray_done), 1);
        check("oob_dropped", int'(dropped_count), 1);
        @(negedge clock);

        // Clear with two cells in flight
        drive_cell(1, 0, 1'b1, 1'b0);
        @(negedge clock);
        drive_cell(2, 0, 1'b0, 1'b1);
        clear_req = 1'b1;
        wi       = 0;
        done_idx = -1;
        done_cnt = 0;
        seen     = 0;
        seq_ok   = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            idle_inputs();
            if (wr_en) begin
                if (wi == 0) begin
                    check("clr_cell1_addr", int'(wr_addr), 1);
                    check("clr_cell1_data", int'($signed(wr_data)), 7);
                end else if (wi == 1) begin
                    check("clr_cell2_addr", int'(wr_addr), 2);
                    check("clr_cell2_data", int'($signed(wr_data)), -3);
                    check("clr_cell2_ray_done", int'(ray_done), 1);
                end else if (int'(wr_addr) != wi - 2 || wr_data != 8'd0 || in_ready) begin
                    seq_ok = 1'b0;
                end
                wi++;
            end
            if (clear_done) begin
                done_cnt++;
                done_idx = wi - 1;
                seen = 1;
                break;
            end
        end
        check("clr_done_seen", seen, 1);
        check("clr_sweep_seq", int'(seq_ok), 1);
        check("clr_write_count", wi, 258);
        check("clr_done_on_final", done_idx, 257);
        @(negedge clock);
        check("clr_in_ready_after", int'(in_ready), 1);
        check("clr_done_once", int'(clear_done), 0);
        nonzero = 0;
        for (int i = 0; i < 256; i++) if (mem[i] != 8'd0) nonzero++;
        check("clr_mem_zero", nonzero, 0);

        // Reset in the middle of a clear sweep
        clear_req = 1'b1;
        @(negedge clock);
        clear_req = 1'b0;
        seen = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clock);
            if (wr_en && wr_addr == 8'd100) begin
                seen = 1;
                break;
            end
        end
        check("rst_reached_addr100", seen, 1);
        check("rst_busy_in_ready", int'(in_ready), 0);
        reset_n = 1'b0;
        #1;
        check("rst_rd_addr", int'(rd_addr), 0);
        check_reset_outputs("rst");
        done_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (clear_done || wr_en) done_cnt++;
        end
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (clear_done || wr_en) done_cnt++;
        end
        check("rst_no_pulse", done_cnt, 0);
        check("rst_in_ready_after", int'(in_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/occupancy_grid_updater.md
Name: occupancy_grid_updater

Overview:
- Consumer end of the ray-tracing datapath's cell-index stream. Accepts (x_index, y_index) pairs per ray cell plus a hit flag marking the endpoint.
- Performs a pipelined read-modify-write of signed log-odds cells in a dual-port map RAM: free cells decrement, the hit cell increments, with saturation.
- Sits between the Bresenham traversal and the map RAM. Also owns whole-map clear and per-ray completion signalling.

Parameters:
- MAP_W, 256, map width in cells (x range 0..MAP_W-1).
- MAP_H, 256, map height in cells (y range 0..MAP_H-1).
- CELL_W, 8, signed log-odds cell width.
- L_OCC, 7, signed increment applied to hit cells.
- L_FREE, -3, signed increment applied to free cells.
- L_MIN, -64, saturation floor.
- L_MAX, 63, saturation ceiling.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  cell presented.
- in_ready  out  1  block accepts the cell this cycle.
- x_index  in  index_t  cell column (unsigned).
- y_index  in  index_t  cell row (unsigned).
- hit  in  1  1 = ray endpoint (L_OCC), 0 = free (L_FREE).
- last  in  1  final cell of the current ray.
- clear_req  in  1  single-cycle pulse requesting a whole-map clear.
- clear_done  out  1  one-cycle pulse when the clear finishes.
- ray_done  out  1  one-cycle pulse when the last cell of a ray has been retired.
- rd_en  out  1  RAM read enable.
- rd_addr  out  ADDR_W  RAM read address.
- rd_data  in  CELL_W  RAM read data, valid the cycle after rd_en. Read-first on same-address collision.
- wr_en  out  1  RAM write enable.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  CELL_W  RAM write data.
- dropped_count  out  16  saturating count of out-of-bounds cells discarded.

Behaviour:
- Address: ADDR_W = clog2(MAP_W*MAP_H); addr = y_index*MAP_W + x_index, computed at accept.
- Reset values: in_ready=1, rd_en=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0, ray_done=0, clear_done=0, dropped_count=0. All pipeline valids cleared; FSM in ACTIVE.
- FSM states:
  - ACTIVE: in_ready=1.
  - DRAIN: in_ready=0; wait until S1 and S2 are empty.
  - CLEAR: in_ready=0; counter sweeps addr 0..MAP_W*MAP_H-1, one write per cycle, wr_data=0.
- FSM transitions:
  - ACTIVE->DRAIN on clear_req.
  - DRAIN->CLEAR when the pipeline is empty.
  - CLEAR->ACTIVE after the final address is written; clear_done pulses in that final write cycle.
  - clear_req outside ACTIVE is ignored.
  - A handshake in the same cycle as clear_req is accepted and drains before the clear.
- Pipeline stages:
  - Handshake at edge T (in_valid & in_ready) loads S1.
  - Cycle T+1 (S1): rd_en=1, rd_addr=addr.
  - Cycle T+2 (S2): new = sat(old + inc), wr_en=1, wr_addr=addr, wr_data=new.
  - Throughput 1 cell/cycle; no back-pressure in ACTIVE.
- Forwarding: if S2 addr equals the address written in the previous cycle (wr_en was 1), old = previous wr_data, not rd_data. Only a one-cycle gap needs this.
- Saturation: add in CELL_W+1 bits, then clamp to [L_MIN, L_MAX].
- Out of bounds: x_index>=MAP_W or y_index>=MAP_H is accepted but flagged invalid.
  - No rd_en/wr_en for that cell; dropped_count increments (saturating at 65535).
  - If it carries last, ray_done still pulses at T+2.
- ray_done: asserted in S2 of the element carrying last, in the same cycle as its wr_en.
- Reset mid-operation: in-flight cells are lost, a pending clear is abandoned, no pulse is produced.

Decomposition:
- ram_pkg gains: MAP_W, MAP_H, ADDR_W, cell_t (signed CELL_W), map_addr_t, L_OCC, L_FREE, L_MIN, L_MAX.
- index_t is reused from ram_pkg.
- One sub-module is natural: log_odds_saturate, a combinational cell_t + increment -> clamped cell_t.

Test Plan:
- Single free cell: MAP_W=MAP_H=16, RAM preloaded 0; x=3,y=2,hit=0,last=1.
  -> rd_addr=35 at T+1; wr_addr=35, wr_data=-3, ray_done=1 at T+2.
- Back-to-back same cell: (5,5) hit=0 then hit=1 on consecutive cycles, preload 10.
  -> writes 7 then 14; forwarding is verified because rd_data returns stale 10.
- Saturation: cell preloaded 60, hit=1 -> 63. Cell preloaded -63, hit=0 -> -64.
- Out of bounds: (16,0) last=1.
  -> no rd_en/wr_en; dropped_count=1; ray_done at T+2.
- Clear mid-stream: clear_req accepted with 2 cells in flight.
  -> both cells written, then 256 consecutive zero writes addr 0..255, clear_done with the final write, in_ready=1 the next cycle.
- Reset mid-clear: reset_n low at clear addr 100.
  -> all outputs return to reset values; no clear_done; in_ready=1 after release.
